// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and types for the fetch PC unit.
// Opcodes, state encoding and address widths.
package fetch_pc_unit_pkg;

  localparam int PC_WIDTH  = 8;
  localparam int LBL_WIDTH = 6;
  localparam int OP_WIDTH  = 4;

  localparam logic [OP_WIDTH-1:0] OP_HLT  = 4'hB;
  localparam logic [OP_WIDTH-1:0] OP_JMP  = 4'hC;
  localparam logic [OP_WIDTH-1:0] OP_BEQZ = 4'hD;
  localparam logic [OP_WIDTH-1:0] OP_CALL = 4'hE;
  localparam logic [OP_WIDTH-1:0] OP_RET  = 4'hF;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef logic [PC_WIDTH-1:0] pc_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-side bundle between the fetch PC unit
// and whatever feeds it opcodes and flags.
interface fetch_pc_unit_if;
  import fetch_pc_unit_pkg::*;

  logic                 start;
  logic                 stall;
  logic [OP_WIDTH-1:0]  OPcode;
  logic [LBL_WIDTH-1:0] label;
  logic                 zero_flag;
  pc_t                  PC;
  logic                 valid;
  logic                 halted;
  logic                 err;

  modport master (
    output start, stall, OPcode, label, zero_flag,
    input  PC, valid, halted, err
  );

  modport slave (
    input  start, stall, OPcode, label, zero_flag,
    output PC, valid, halted, err
  );

endinterface

// File: rtl/fetch_pc_unit_ret_stack.sv
// LIFO of return addresses; top of stack is read
// combinationally so RET can redirect in one cycle.
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_m1;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign cnt_m1  = cnt_q - CW'(1);
  assign wr_idx  = cnt_q[AW-1:0];
  assign top_idx = cnt_m1[AW-1:0];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[top_idx];
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (do_push) begin
      cnt_q <= cnt_q + CW'(1);
    end else if (do_pop) begin
      cnt_q <= cnt_m1;
    end
  end

  // Entries are only meaningful below cnt_q, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch program counter with JMP/BEQZ/CALL/RET/HLT
// redirection and a small return-address stack.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int PC_WRAP     = 63
) (
  input  logic            clock,
  input  logic            resetn,
  fetch_pc_unit_if.slave  bus
);

  state_e state_q, state_d;
  pc_t    pc_q, pc_d;
  logic   err_q, err_d;
  pc_t    seq;
  pc_t    tgt;
  pc_t    top;
  logic   push, pop, clr;
  logic   full, empty;

  ret_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_WIDTH)
  ) u_stack (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .clr_i   (clr),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (seq),
    .data_o  (top),
    .full_o  (full),
    .empty_o (empty)
  );

  assign seq = (pc_q == PC_WRAP[PC_WIDTH-1:0])
             ? '0 : pc_q + PC_WIDTH'(1);
  assign tgt = {{(PC_WIDTH-LBL_WIDTH){1'b0}}, bus.label};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      ST_HALT: begin
        if (bus.start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          err_d   = 1'b0;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.stall) begin
          unique case (1'b1)
            (bus.OPcode == OP_HLT): state_d = ST_HALT;
            (bus.OPcode == OP_JMP): pc_d = tgt;
            (bus.OPcode == OP_BEQZ):
              pc_d = bus.zero_flag ? tgt : seq;
            (bus.OPcode == OP_CALL): begin
              if (full) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                push = 1'b1;
                pc_d = tgt;
              end
            end
            (bus.OPcode == OP_RET): begin
              if (empty) begin
                err_d   = 1'b1;
                state_d = ST_HALT;
              end else begin
                pop  = 1'b1;
                pc_d = top;
              end
            end
            default: pc_d = seq;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_HALT;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign bus.PC     = pc_q;
  assign bus.valid  = (state_q == ST_RUN);
  assign bus.halted = (state_q == ST_HALT);
  assign bus.err    = err_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios plus random
// programs against a queue-based reference model.
module tb_fetch_pc_unit;

  localparam int DEPTH = 4;
  localparam int WRAP  = 63;

  logic clock;
  logic resetn;
  fetch_pc_unit_if bus();

  fetch_pc_unit #(
    .STACK_DEPTH (DEPTH),
    .PC_WRAP     (WRAP)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec;
  int n_err;

  logic [3:0] imem_op [64];
  logic [5:0] imem_lb [64];

  int m_pc;
  bit m_run;
  bit m_err;
  int m_stk [$];

  bit start_r;
  bit stall_r;
  bit zf_r;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc  = 0;
    m_run = 0;
    m_err = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input bit st, input bit sl,
                            input logic [3:0] op,
                            input logic [5:0] lb,
                            input bit zf);
    int nxt;
    nxt = (m_pc + 1) % (WRAP + 1);
    if (!m_run) begin
      if (st) begin
        m_run = 1;
        m_pc  = 0;
        m_err = 0;
        m_stk.delete();
      end
    end else if (!sl) begin
      case (op)
        4'hB: m_run = 0;
        4'hC: m_pc = int'(lb);
        4'hD: m_pc = zf ? int'(lb) : nxt;
        4'hE: begin
          if (m_stk.size() == DEPTH) begin
            m_err = 1;
            m_run = 0;
          end else begin
            m_stk.push_back(nxt);
            m_pc = int'(lb);
          end
        end
        4'hF: begin
          if (m_stk.size() == 0) begin
            m_err = 1;
            m_run = 0;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        default: m_pc = nxt;
      endcase
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".pc"}, 32'(bus.PC), 32'(m_pc));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(m_run));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(!m_run));
    chk({tag, ".err"}, 32'(bus.err), 32'(m_err));
  endtask

  task automatic tick();
    logic [3:0] op;
    logic [5:0] lb;
    op = imem_op[m_pc];
    lb = imem_lb[m_pc];
    bus.OPcode    = op;
    bus.label     = lb;
    bus.start     = start_r;
    bus.stall     = stall_r;
    bus.zero_flag = zf_r;
    @(posedge clock);
    model_step(start_r, stall_r, op, lb, zf_r);
    @(negedge clock);
    chk_state("tick");
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) begin
      imem_op[i] = 4'h0;
      imem_lb[i] = 6'h0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("rst.pc", 32'(bus.PC), 32'd0);
    chk("rst.halted", 32'(bus.halted), 32'd1);
    chk("rst.valid", 32'(bus.valid), 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    @(negedge clock);
    resetn  = 1'b1;
    start_r = 0;
    stall_r = 0;
    zf_r    = 0;
  endtask

  task automatic go(input int n);
    start_r = 1;
    tick();
    start_r = 0;
    repeat (n) tick();
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    resetn = 1'b0;
    start_r = 0;
    stall_r = 0;
    zf_r    = 0;
    bus.start = 0;
    bus.stall = 0;
    bus.OPcode = '0;
    bus.label = '0;
    bus.zero_flag = 0;
    model_reset();
    clear_imem();
    #1;
    chk("por.pc", 32'(bus.PC), 32'd0);
    chk("por.halted", 32'(bus.halted), 32'd1);
    @(negedge clock);
    resetn = 1'b1;

    // Release alone must not start fetching.
    tick();
    chk("idle.halted", 32'(bus.halted), 32'd1);

    // Linear walk with wrap at the top address.
    go(0);
    chk("seq.valid0", 32'(bus.valid), 32'd1);
    chk("seq.pc0", 32'(bus.PC), 32'd0);
    repeat (63) tick();
    chk("seq.pc63", 32'(bus.PC), 32'd63);
    tick();
    chk("seq.wrap", 32'(bus.PC), 32'd0);

    // BEQZ taken and not taken.
    do_reset();
    imem_op[5] = 4'hD;
    imem_lb[5] = 6'd20;
    go(5);
    chk("beqz.at", 32'(bus.PC), 32'd5);
    zf_r = 1;
    tick();
    chk("beqz.taken", 32'(bus.PC), 32'd20);
    do_reset();
    go(5);
    zf_r = 0;
    tick();
    chk("beqz.fall", 32'(bus.PC), 32'd6);

    // CALL then RET.
    do_reset();
    clear_imem();
    imem_op[10] = 4'hE;
    imem_lb[10] = 6'd30;
    imem_op[30] = 4'hF;
    go(10);
    chk("call.at", 32'(bus.PC), 32'd10);
    tick();
    chk("call.tgt", 32'(bus.PC), 32'd30);
    tick();
    chk("ret.pc", 32'(bus.PC), 32'd11);
    chk("ret.err", 32'(bus.err), 32'd0);

    // Overflow on fifth nested CALL, then RET on empty stack.
    do_reset();
    clear_imem();
    for (int i = 0; i < 5; i++) begin
      imem_op[i] = 4'hE;
      imem_lb[i] = 6'(i + 1);
    end
    go(5);
    chk("ovf.err", 32'(bus.err), 32'd1);
    chk("ovf.halted", 32'(bus.halted), 32'd1);
    chk("ovf.pc", 32'(bus.PC), 32'd4);
    tick();
    chk("ovf.hold", 32'(bus.PC), 32'd4);
    imem_op[0] = 4'hF;
    go(0);
    chk("restart.err", 32'(bus.err), 32'd0);
    tick();
    chk("unf.err", 32'(bus.err), 32'd1);
    chk("unf.halted", 32'(bus.halted), 32'd1);

    // Stall during JMP.
    do_reset();
    clear_imem();
    imem_op[7] = 4'hC;
    imem_lb[7] = 6'd40;
    go(7);
    stall_r = 1;
    for (int i = 0; i < 3; i++) begin
      start_r = (i == 1);
      tick();
      chk("stall.pc", 32'(bus.PC), 32'd7);
    end
    start_r = 0;
    stall_r = 0;
    tick();
    chk("jmp.pc", 32'(bus.PC), 32'd40);

    // Asynchronous reset mid-cycle while running.
    do_reset();
    clear_imem();
    go(12);
    chk("arst.pre", 32'(bus.PC), 32'd12);
    do_reset();
    tick();
    chk("arst.idle", 32'(bus.halted), 32'd1);

    // HLT holds its own address.
    imem_op[3] = 4'hB;
    go(3);
    tick();
    chk("hlt.halted", 32'(bus.halted), 32'd1);
    chk("hlt.pc", 32'(bus.PC), 32'd3);
    tick();
    chk("hlt.hold", 32'(bus.PC), 32'd3);

    // Random programs and control inputs.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 64; i++) begin
        imem_op[i] = 4'($urandom_range(0, 15));
        imem_lb[i] = 6'($urandom_range(0, 63));
      end
      if (blk % 3 == 0) do_reset();
      for (int c = 0; c < 100; c++) begin
        start_r = ($urandom_range(0, 9) < 4);
        stall_r = ($urandom_range(0, 9) < 2);
        zf_r    = $urandom_range(0, 1) == 1;
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
